instr_sequencer: RTL

Multi-cycle sequencer for the processor's integer datapath.
- Fetches an instruction over a req/ack handshake and decodes it (funct, shift class, load-immediate flag).
- Issues the datapath enables: ALU op, iterative shift steps, register write-back and PC increment, one phase per cycle.
- Sits between instruction memory and the register file / ALU / shifter.
- Replaces purely combinational control when shifts are executed one bit per cycle.

---
 rtl/instr_sequencer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/instr_sequencer.sv
// Multi-cycle integer-datapath sequencer: fetch over req/ack, decode, iterative shift, exec, write-back.
// Optional performance counters (retired_cnt, stall_cnt) are enabled by defining SEQ_PERF_CNT_EN.
module instr_sequencer #(
   parameter int XLEN          = 32,
   parameter int SHAMT_W       = 5,
   parameter int FETCH_TIMEOUT = 15
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            run,
   output logic            instr_req,
   input  logic            instr_ack,
   input  logic [XLEN-1:0] instr_rdata,
   output logic [3:0]      alu_op,
   output logic            shift_cond,
   output logic            load_int_cond,
   output logic            shift_step,
   output logic            alu_en,
   output logic            reg_write,
   output logic            pc_inc,
   output logic            busy,
   output logic            fault
`ifdef SEQ_PERF_CNT_EN
   ,
   output logic [31:0]     retired_cnt,
   output logic [31:0]     stall_cnt
`endif
);

   localparam int TMO_W = $clog2(FETCH_TIMEOUT + 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_SHIFT  = 3'd3,
      ST_EXEC   = 3'd4,
      ST_WB     = 3'd5
   } state_t;

   state_t             state_r;
   state_t             state_next_s;
   logic [XLEN-1:0]    ir_r;
   logic [SHAMT_W-1:0] shift_cnt_r;
   logic [SHAMT_W-1:0] shamt_s;
   logic [TMO_W-1:0]   tmo_cnt_r;
   logic               timeout_s;

   function automatic logic is_shift_funct(input logic [3:0] funct);
      return (funct == 4'd0) || (funct == 4'd2);
   endfunction

   assign shamt_s   = ir_r[4 +: SHAMT_W];
   assign timeout_s = (state_r == ST_FETCH) && !instr_ack &&
                      (tmo_cnt_r == TMO_W'(FETCH_TIMEOUT - 1));

   // Next-state selection; ack takes priority over the timeout on the last allowed cycle
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (run && !fault) state_next_s = ST_FETCH;
            else               state_next_s = ST_IDLE;
         end
         ST_FETCH: begin
            if (instr_ack)      state_next_s = ST_DECODE;
            else if (timeout_s) state_next_s = ST_IDLE;
            else                state_next_s = ST_FETCH;
         end
         ST_DECODE: begin
            if (is_shift_funct(ir_r[3:0]) && (shamt_s != {SHAMT_W{1'b0}})) state_next_s = ST_SHIFT;
            else                                                           state_next_s = ST_EXEC;
         end
         ST_SHIFT: begin
            if (shift_cnt_r == SHAMT_W'(1)) state_next_s = ST_WB;
            else                            state_next_s = ST_SHIFT;
         end
         ST_EXEC: state_next_s = ST_WB;
         ST_WB: begin
            if (run) state_next_s = ST_FETCH;
            else     state_next_s = ST_IDLE;
         end
         default: state_next_s = ST_IDLE;
      endcase
   end

   // State, datapath counters and registered outputs decoded from the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= ST_IDLE;
         ir_r          <= {XLEN{1'b0}};
         shift_cnt_r   <= {SHAMT_W{1'b0}};
         tmo_cnt_r     <= {TMO_W{1'b0}};
         instr_req     <= 1'b0;
         shift_step    <= 1'b0;
         alu_en        <= 1'b0;
         reg_write     <= 1'b0;
         pc_inc        <= 1'b0;
         busy          <= 1'b0;
         fault         <= 1'b0;
         alu_op        <= 4'd0;
         shift_cond    <= 1'b0;
         load_int_cond <= 1'b0;
      end else begin
         state_r    <= state_next_s;
         instr_req  <= (state_next_s == ST_FETCH);
         shift_step <= (state_next_s == ST_SHIFT);
         alu_en     <= (state_next_s == ST_EXEC);
         reg_write  <= (state_next_s == ST_WB);
         pc_inc     <= (state_next_s == ST_WB);
         busy       <= (state_next_s != ST_IDLE);

         if (timeout_s) fault <= 1'b1;

         if ((state_r == ST_FETCH) && !instr_ack && !timeout_s) tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
         else                                                   tmo_cnt_r <= {TMO_W{1'b0}};

         if ((state_r == ST_FETCH) && instr_ack) ir_r <= instr_rdata;

         if (state_r == ST_DECODE)     shift_cnt_r <= shamt_s;
         else if (state_r == ST_SHIFT) shift_cnt_r <= shift_cnt_r - SHAMT_W'(1);

         // IR loads on the same edge, so decode straight from the fetched word
         case (state_next_s)
            ST_DECODE: begin
               alu_op        <= instr_rdata[3:0];
               shift_cond    <= is_shift_funct(instr_rdata[3:0]);
               load_int_cond <= instr_rdata[XLEN-1];
            end
            ST_SHIFT, ST_EXEC, ST_WB: begin
               alu_op        <= alu_op;
               shift_cond    <= shift_cond;
               load_int_cond <= load_int_cond;
            end
            default: begin
               alu_op        <= 4'd0;
               shift_cond    <= 1'b0;
               load_int_cond <= 1'b0;
            end
         endcase
      end
   end

`ifdef SEQ_PERF_CNT_EN
   // Retired-instruction and fetch-stall counters, both free-running with wrap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retired_cnt <= 32'd0;
         stall_cnt   <= 32'd0;
      end else begin
         if (state_r == ST_WB)                  retired_cnt <= retired_cnt + 32'd1;
         if ((state_r == ST_FETCH) && !instr_ack) stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule
